alu_icc_pipe: RTL and testbench

- Parametrised, registered successor of the 32-bit SPARC integer ALU.
- Accepts one operation per cycle through a valid/ready handshake and registers the result.
- Owns the integer condition codes (icc N,Z,V,C) as internal state. ADDX/SUBX read the registered carry, so back-to-back dependent ops chain correctly.
- Sits between the register-file read stage and the writeback stage of the integer pipeline.

---
 rtl/alu_icc_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_alu_icc_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_icc_pipe.sv
// Registered SPARC-style integer ALU that owns the icc flags {N,Z,V,C}.
// Define ALU_MUL_EN to add UMUL/SMUL via an iterative shift-add unit and y_hi.
module alu_icc_pipe #(
    parameter int         WIDTH   = 32,
    parameter int         SHAMT_W = $clog2(WIDTH),
    parameter logic [3:0] ICC_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_err,
    output logic [3:0]       icc,
    input  logic             icc_we,
    input  logic [3:0]       icc_wdata
`ifdef ALU_MUL_EN
    ,
    output logic [WIDTH-1:0] y_hi
`endif
);

    localparam int M = WIDTH - 1;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [3:0]       r_icc;

    logic             w_free;
    logic             w_acc;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_sra;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_err;
    logic             w_v;
    logic             w_c;
    logic             w_upd;
    logic             w_is_mul;
    logic             w_mul_done;

    // ADDX/SUBX chain through the registered carry
    assign w_cin   = opcode[3] & r_icc[0];
    assign w_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
    assign w_dif   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
    assign w_shamt = b[SHAMT_W-1:0];
    assign w_sra   = $unsigned($signed(a) >>> w_shamt);
    assign w_free  = !r_valid || out_ready;
    assign w_acc   = in_valid && in_ready;

    always_comb begin
        w_res    = '0;
        w_err    = 1'b0;
        w_v      = 1'b0;
        w_c      = 1'b0;
        w_is_mul = 1'b0;
        if (!opcode[5]) begin
            unique case (opcode[3:0])
                4'b0000, 4'b1000: begin
                    w_res = w_sum[M:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = (a[M] == b[M]) && (w_sum[M] != a[M]);
                end
                4'b0100, 4'b1100: begin
                    w_res = w_dif[M:0];
                    w_c   = w_dif[WIDTH];
                    w_v   = (a[M] != b[M]) && (w_dif[M] != a[M]);
                end
                4'b0001: w_res = a & b;
                4'b0101: w_res = a & ~b;
                4'b0010: w_res = a | b;
                4'b0110: w_res = a | ~b;
                4'b0011: w_res = a ^ b;
                4'b0111: w_res = ~(a ^ b);
`ifdef ALU_MUL_EN
                4'b1010, 4'b1011: w_is_mul = 1'b1;
`endif
                default: w_err = 1'b1;
            endcase
        end else begin
            unique case (opcode)
                6'b100101: w_res = a << w_shamt;
                6'b100110: w_res = a >> w_shamt;
                6'b100111: w_res = w_sra;
                default:   w_err = 1'b1;
            endcase
        end
    end

    assign w_upd = !opcode[5] && opcode[4] && !w_err && !w_is_mul;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplr;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_neg;
    logic                 r_s;
    logic [WIDTH-1:0]     r_y_hi;
    logic                 w_smul;
    logic [WIDTH-1:0]     w_amag;
    logic [WIDTH-1:0]     w_bmag;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_smul   = opcode[0];
    assign w_amag   = (w_smul && a[M]) ? -a : a;
    assign w_bmag   = (w_smul && b[M]) ? -b : b;
    assign w_prod   = r_neg ? -r_prod : r_prod;
    assign in_ready = w_free && (r_state == S_IDLE);
    assign w_mul_done = (r_state == S_DONE) && w_free;
    assign y_hi     = r_y_hi;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_acc && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (w_free) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Unsigned shift-add on magnitudes; sign restored at the end for SMUL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_prod  <= '0;
            r_neg   <= 1'b0;
            r_s     <= 1'b0;
            r_y_hi  <= '0;
        end else begin
            if (w_acc && w_is_mul) begin
                r_cnt   <= SHAMT_W'(WIDTH - 1);
                r_mcand <= {{WIDTH{1'b0}}, w_amag};
                r_mplr  <= w_bmag;
                r_prod  <= '0;
                r_neg   <= w_smul && (a[M] ^ b[M]);
                r_s     <= opcode[4];
            end else if (r_state == S_MUL) begin
                if (r_mplr[0]) r_prod <= r_prod + r_mcand;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_cnt   <= r_cnt - 1'b1;
            end
            if (w_mul_done) r_y_hi <= w_prod[2*WIDTH-1:WIDTH];
        end
    end
`else
    assign in_ready   = w_free;
    assign w_mul_done = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_acc && !w_is_mul) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_err    <= w_err;
`ifdef ALU_MUL_EN
        end else if (w_mul_done) begin
            r_valid  <= 1'b1;
            r_result <= w_prod[M:0];
            r_err    <= 1'b0;
`endif
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_icc <= ICC_RST;
        end else if (icc_we) begin
            r_icc <= icc_wdata;
        end else if (w_acc && w_upd) begin
            r_icc <= {w_res[M], w_res == '0, w_v, w_c};
`ifdef ALU_MUL_EN
        end else if (w_mul_done && r_s) begin
            r_icc <= {w_prod[M], w_prod[M:0] == '0, 2'b00};
`endif
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;
    assign out_err   = r_err;
    assign icc       = r_icc;

endmodule

// File: tb/tb_alu_icc_pipe.sv
// Directed bench for alu_icc_pipe (default build) with a result scoreboard.
module tb_alu_icc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_err;
    logic [3:0]  icc;
    logic        icc_we;
    logic [3:0]  icc_wdata;

    int          checks = 0;
    int          errors = 0;
    int          n_push = 0;
    int          n_pop  = 0;
    logic [32:0] q[$];
    logic [31:0] cur_res;
    logic        cur_err;

    alu_icc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_err   (out_err),
        .icc       (icc),
        .icc_we    (icc_we),
        .icc_wdata (icc_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sample at negedge: push on accept, pop/compare on output handshake
    task automatic step(output bit acc);
        logic [32:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) begin
            q.push_back({cur_err, cur_res});
            n_push++;
        end
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow got=%h exp=none", result);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                n_pop++;
                chk("sb_result", result, e[31:0]);
                chk("sb_err", {31'd0, out_err}, {31'd0, e[32]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [5:0] o, input logic [31:0] ia,
                      input logic [31:0] ib, input logic [31:0] er,
                      input logic ee);
        bit acc;
        int n;
        opcode   = o;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        cur_res  = er;
        cur_err  = ee;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL accept_timeout op=%b got=0 exp=1", o);
        end
    endtask

    initial begin
        bit acc;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        icc_we    = 1'b0;
        icc_wdata = '0;
        cur_res   = '0;
        cur_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_icc", {28'd0, icc}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        op(6'b010000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        chk("addcc_icc", {28'd0, icc}, 32'h5);
        op(6'b001000, 32'd5, 32'd5, 32'd11, 1'b0);
        chk("addx_icc", {28'd0, icc}, 32'h5);

        op(6'b010100, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
        chk("subcc_icc", {28'd0, icc}, 32'h9);
        op(6'b010100, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0);
        chk("subcc_ovf_icc", {28'd0, icc}, 32'h2);

        op(6'b010000, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0);
        chk("addcc_c_icc", {28'd0, icc}, 32'h1);
        op(6'b011100, 32'd10, 32'd3, 32'd6, 1'b0);
        chk("subxcc_icc", {28'd0, icc}, 32'h0);

        op(6'b100111, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);
        chk("sra_icc", {28'd0, icc}, 32'h0);
        op(6'b100101, 32'd1, 32'h21, 32'd2, 1'b0);
        op(6'b100110, 32'h80000000, 32'd4, 32'h08000000, 1'b0);

        op(6'b010101, 32'hF0F0, 32'h00FF, 32'hF000, 1'b0);
        chk("andncc_icc", {28'd0, icc}, 32'h0);
        op(6'b010111, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);
        chk("xnorcc_icc", {28'd0, icc}, 32'h8);
        op(6'b000110, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
        chk("orn_icc", {28'd0, icc}, 32'h8);

        op(6'b111111, 32'd7, 32'd9, 32'd0, 1'b1);
        chk("illegal_icc", {28'd0, icc}, 32'h8);
        op(6'b001010, 32'd3, 32'd4, 32'd0, 1'b1);
        op(6'b110101, 32'd3, 32'd4, 32'd0, 1'b1);

        icc_we    = 1'b1;
        icc_wdata = 4'b1010;
        op(6'b010000, 32'd1, 32'd1, 32'd2, 1'b0);
        icc_we    = 1'b0;
        chk("iccwe_wins", {28'd0, icc}, 32'hA);
        in_valid  = 1'b0;
        icc_we    = 1'b1;
        icc_wdata = 4'b0101;
        step(acc);
        icc_we    = 1'b0;
        chk("iccwe_alone", {28'd0, icc}, 32'h5);

        out_ready = 1'b0;
        op(6'b000000, 32'd1, 32'd2, 32'd3, 1'b0);
        opcode   = 6'b000011;
        a        = 32'hFF;
        b        = 32'h0F;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold", result, 32'd3);
            step(acc);
        end
        out_ready = 1'b1;
        op(6'b000011, 32'hFF, 32'h0F, 32'hF0, 1'b0);
        op(6'b000010, 32'h100, 32'd1, 32'h101, 1'b0);

        in_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 30) begin
            step(acc);
            n++;
        end
        chk("drain_empty", q.size(), 32'd0);
        chk("push_pop", n_pop, n_push);
        chk("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
